quad_trackball_gen: RTL



---
 rtl/ccastles_pkg.sv | 18 +
 rtl/quad_axis.sv | 87 ++++++++
 rtl/quad_trackball_gen.sv | 74 +++++++
 3 files changed

// File: rtl/ccastles_pkg.sv
// Shared Crystal Castles definitions.
// Quadrature phase table, step directions and accumulator limits.
package ccastles_pkg;

  localparam logic [1:0] QUAD_PHASE [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef enum logic [1:0] {
    POS,
    NEG,
    NONE
  } step_dir_t;

  // Symmetric limit so that negation never overflows
  function automatic int acc_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/quad_axis.sv
// One trackball axis.
// Pending-step accumulator with saturation, quadrature phase and A/B outputs.
module quad_axis
  import ccastles_pkg::*;
#(
  parameter int ACC_W = 10,
  parameter bit INV   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       strobe,
  input  logic [8:0] d,
  input  logic       flush,
  output logic       a,
  output logic       b,
  output logic       nz
);

  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAX = SW'(acc_max(ACC_W));
  localparam logic signed [SW-1:0] MIN = -MAX;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [1:0] p;
  logic [1:0] p_nxt;
  step_dir_t dir;
  logic signed [SW-1:0] dw;
  logic signed [SW-1:0] sv;
  logic signed [SW-1:0] sum;

  always_comb begin
    dir = NONE;
    if (tick && !flush) begin
      if (acc > 0)      dir = POS;
      else if (acc < 0) dir = NEG;
    end
  end

  // Widened so that negating -256 cannot wrap
  always_comb begin
    dw = {{(SW-9){d[8]}}, d};
    if (INV) dw = -dw;
    sv = '0;
    unique case (1'b1)
      dir == POS: sv = SW'(1);
      dir == NEG: sv = -SW'(1);
      default:    sv = '0;
    endcase
    sum = {{2{acc[ACC_W-1]}}, acc} + dw - sv;
  end

  always_comb begin
    acc_nxt = acc;
    p_nxt   = p;
    if (flush) begin
      acc_nxt = '0;
    end else begin
      if (dir == POS)      p_nxt = p + 2'd1;
      else if (dir == NEG) p_nxt = p - 2'd1;
      if (strobe) begin
        if (sum > MAX)      acc_nxt = MAX[ACC_W-1:0];
        else if (sum < MIN) acc_nxt = MIN[ACC_W-1:0];
        else                acc_nxt = sum[ACC_W-1:0];
      end else if (dir == POS) begin
        acc_nxt = acc - ACC_W'(1);
      end else if (dir == NEG) begin
        acc_nxt = acc + ACC_W'(1);
      end
    end
    nz = (acc_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      p      <= 2'd0;
      {a, b} <= 2'b00;
    end else begin
      acc    <= acc_nxt;
      p      <= p_nxt;
      {a, b} <= QUAD_PHASE[p_nxt];
    end
  end

endmodule

// File: rtl/quad_trackball_gen.sv
// Trackball emulator: mouse deltas in, paced quadrature edges out.
// Holds the shared step divider, the busy flag and one quad_axis per axis.
module quad_trackball_gen
  import ccastles_pkg::*;
#(
  parameter int STEP_DIV = 2500,
  parameter int ACC_W    = 10,
  parameter bit INV_X    = 1'b0,
  parameter bit INV_Y    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       strobe,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  input  logic       flush,
  output logic       xa,
  output logic       xb,
  output logic       ya,
  output logic       yb,
  output logic       busy
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;
  logic tick;
  logic nz_x;
  logic nz_y;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= tick ? '0 : cnt + CW'(1);
      busy <= nz_x | nz_y;
    end
  end

  quad_axis #(
    .ACC_W(ACC_W),
    .INV  (INV_X)
  ) u_x (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick),
    .strobe (strobe),
    .d      (dx),
    .flush  (flush),
    .a      (xa),
    .b      (xb),
    .nz     (nz_x)
  );

  quad_axis #(
    .ACC_W(ACC_W),
    .INV  (INV_Y)
  ) u_y (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick),
    .strobe (strobe),
    .d      (dy),
    .flush  (flush),
    .a      (ya),
    .b      (yb),
    .nz     (nz_y)
  );

endmodule
